decoder_iter_ctrl: RTL and testbench

//   Sequences one neural min-sum decode per LLR frame. Waits for the LLR loader to report a

---
 rtl/decoder_iter_ctrl.sv | 150 +++++++++++++++
 tb/tb_decoder_iter_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_iter_ctrl.sv
// Iteration sequencer for a neural min-sum decoder: VN/CN phase handshakes per iteration,
// output-layer start, consumer hold and loader release, with early stop and per-wait watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a full LLR frame
// VN_GO    | vn_start pulse for iteration iter_idx
// VN_WAIT  | waiting for vn_done (watchdog running)
// CN_GO    | cn_start pulse for iteration iter_idx
// CN_WAIT  | waiting for cn_done, decide next iteration / finish
// OUT_GO   | out_start pulse to the output layer
// OUT_WAIT | waiting for out_done (watchdog running)
// HOLD     | out_valid, waiting for consumer accept (no watchdog)
// RELEASE  | llr_release pulse, frame retired
module decoder_iter_ctrl #(
  parameter int N_ITER     = 5,
  parameter int ITER_W     = 4,
  parameter int EARLY_TERM = 1,
  parameter int WDOG_CYC   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              llrs_loaded,
  output logic              llr_release,
  output logic              vn_start,
  input  logic              vn_done,
  output logic              cn_start,
  input  logic              cn_done,
  input  logic              syndrome_ok,
  output logic [ITER_W-1:0] iter_idx,
  output logic              out_start,
  input  logic              out_done,
  output logic              out_valid,
  input  logic              out_accept,
  output logic              busy,
  output logic              early_stop,
  output logic              wdog_err
);

  localparam int WD_W = $clog2(WDOG_CYC + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);
  localparam logic [WD_W-1:0]   WDOG_LAST = WD_W'(WDOG_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, VN_GO, VN_WAIT, CN_GO, CN_WAIT, OUT_GO, OUT_WAIT, HOLD, RELEASE
  } state_t;

  state_t            state, state_nxt;
  logic [ITER_W-1:0] iter_nxt;
  logic [WD_W-1:0]   wdog_cnt, wdog_nxt;
  logic              early_nxt;
  logic              wdog_err_nxt;
  logic              wdog_hit;

  // Abort on the WDOG_CYC-th wait cycle; a done arriving in that same cycle still wins.
  assign wdog_hit = (wdog_cnt == WDOG_LAST);

  always_comb begin
    state_nxt    = state;
    iter_nxt     = iter_idx;
    early_nxt    = early_stop;
    wdog_err_nxt = wdog_err;
    wdog_nxt     = '0;
    case (state)
      IDLE: begin
        if (llrs_loaded) begin
          state_nxt = VN_GO;
          iter_nxt  = '0;
          early_nxt = 1'b0;
        end
      end
      VN_GO: state_nxt = VN_WAIT;
      VN_WAIT: begin
        if (vn_done) begin
          state_nxt = CN_GO;
        end else if (wdog_hit) begin
          state_nxt    = RELEASE;
          wdog_err_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog_cnt + WD_W'(1);
        end
      end
      CN_GO: state_nxt = CN_WAIT;
      CN_WAIT: begin
        if (cn_done) begin
          if ((EARLY_TERM != 0) && syndrome_ok) begin
            state_nxt = OUT_GO;
            early_nxt = 1'b1;
          end else if (iter_idx == ITER_LAST) begin
            state_nxt = OUT_GO;
          end else begin
            state_nxt = VN_GO;
            iter_nxt  = iter_idx + ITER_W'(1);
          end
        end else if (wdog_hit) begin
          state_nxt    = RELEASE;
          wdog_err_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog_cnt + WD_W'(1);
        end
      end
      OUT_GO: state_nxt = OUT_WAIT;
      OUT_WAIT: begin
        if (out_done) begin
          state_nxt = HOLD;
        end else if (wdog_hit) begin
          state_nxt    = RELEASE;
          wdog_err_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog_cnt + WD_W'(1);
        end
      end
      HOLD: begin
        if (out_accept) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      iter_idx    <= '0;
      wdog_cnt    <= '0;
      early_stop  <= 1'b0;
      wdog_err    <= 1'b0;
      llr_release <= 1'b0;
      vn_start    <= 1'b0;
      cn_start    <= 1'b0;
      out_start   <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      iter_idx    <= iter_nxt;
      wdog_cnt    <= wdog_nxt;
      early_stop  <= early_nxt;
      wdog_err    <= wdog_err_nxt;
      llr_release <= (state_nxt == RELEASE);
      vn_start    <= (state_nxt == VN_GO);
      cn_start    <= (state_nxt == CN_GO);
      out_start   <= (state_nxt == OUT_GO);
      out_valid   <= (state_nxt == HOLD);
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_decoder_iter_ctrl.sv
// Scoreboard bench for decoder_iter_ctrl: instance 0 with early termination, instance 1 without,
// both with an 8-cycle watchdog. Datapath responders answer each start 2 cycles later.
module tb_decoder_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] llrs_loaded, llr_release, vn_start, vn_done, cn_start, cn_done, syndrome_ok;
  logic [1:0] out_start, out_done, out_valid, out_accept, busy, early_stop, wdog_err;
  logic [3:0] iter_idx [2];

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q [$];
  logic [1:0] vprev   = '0;
  bit         cn_dead = 1'b0;
  bit         stray_vn = 1'b0;
  int         synd_on = 0;
  int         cn_cnt  = 0;

  always #5 clk = ~clk;

  decoder_iter_ctrl #(.N_ITER(5), .ITER_W(4), .EARLY_TERM(1), .WDOG_CYC(8)) dut0 (
    .clk(clk), .rst(rst), .llrs_loaded(llrs_loaded[0]), .llr_release(llr_release[0]),
    .vn_start(vn_start[0]), .vn_done(vn_done[0]), .cn_start(cn_start[0]), .cn_done(cn_done[0]),
    .syndrome_ok(syndrome_ok[0]), .iter_idx(iter_idx[0]), .out_start(out_start[0]),
    .out_done(out_done[0]), .out_valid(out_valid[0]), .out_accept(out_accept[0]),
    .busy(busy[0]), .early_stop(early_stop[0]), .wdog_err(wdog_err[0]));

  decoder_iter_ctrl #(.N_ITER(5), .ITER_W(4), .EARLY_TERM(0), .WDOG_CYC(8)) dut1 (
    .clk(clk), .rst(rst), .llrs_loaded(llrs_loaded[1]), .llr_release(llr_release[1]),
    .vn_start(vn_start[1]), .vn_done(vn_done[1]), .cn_start(cn_start[1]), .cn_done(cn_done[1]),
    .syndrome_ok(syndrome_ok[1]), .iter_idx(iter_idx[1]), .out_start(out_start[1]),
    .out_done(out_done[1]), .out_valid(out_valid[1]), .out_accept(out_accept[1]),
    .busy(busy[1]), .early_stop(early_stop[1]), .wdog_err(wdog_err[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ev(input int g, input int kind, input int val);
    logic [7:0] r;
    r = {g[0], kind[2:0], val[3:0]};
    return r;
  endfunction

  function automatic logic [11:0] outs(input int g);
    return {llr_release[g], vn_start[g], cn_start[g], out_start[g], out_valid[g], busy[g],
            early_stop[g], wdog_err[g], iter_idx[g]};
  endfunction

  task automatic sb_check(input logic [7:0] code);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk("evt_unexp", code, 8'hFF);
    end else begin
      e = exp_q.pop_front();
      chk("evt", code, e);
    end
  endtask

  // Monitor: every start/release pulse and each out_valid rise is one scoreboard event.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (vn_start[g])    sb_check(ev(g, 1, int'(iter_idx[g])));
      if (cn_start[g])    sb_check(ev(g, 2, int'(iter_idx[g])));
      if (out_start[g])   sb_check(ev(g, 3, int'(iter_idx[g])));
      if (llr_release[g]) sb_check(ev(g, 4, int'(wdog_err[g])));
      if (out_valid[g] && !vprev[g]) sb_check(ev(g, 5, int'(early_stop[g])));
      vprev[g] = out_valid[g];
    end
  end

  // Datapath responder: done 2 cycles after each start; syndrome_ok is noise except on the
  // selected cn_done of the frame.
  always @(negedge clk) begin : resp
    bit is_cn;
    for (int g = 0; g < 2; g++) begin
      if (vn_start[g] && iter_idx[g] == 4'd0) cn_cnt = 0;
      if (vn_start[g] || (cn_start[g] && !cn_dead) || out_start[g]) begin
        is_cn = cn_start[g];
        repeat (2) @(posedge clk);
        #1;
        if (is_cn) begin
          cn_cnt++;
          cn_done[g]     = 1'b1;
          syndrome_ok[g] = (cn_cnt == synd_on);
        end else if (vn_start[g] === 1'b0 && out_valid[g] === 1'b0 && busy[g]) begin
          if (iter_idx[g] !== 4'hx) begin end
        end
        if (!is_cn) begin
          vn_done[g]  = 1'b1;
          out_done[g] = 1'b1;
        end
        @(posedge clk);
        #1;
        vn_done[g]     = 1'b0;
        cn_done[g]     = 1'b0;
        out_done[g]    = 1'b0;
        syndrome_ok[g] = 1'($urandom_range(0, 1));
      end
    end
    if (stray_vn) begin
      vn_done[0] = 1'b1;
      @(posedge clk);
      #1;
      vn_done[0] = 1'b0;
    end
  end

  task automatic run_frame(input int g, input int n, input bit early, input int hold);
    int t;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ev(g, 1, i));
      exp_q.push_back(ev(g, 2, i));
    end
    exp_q.push_back(ev(g, 3, n - 1));
    exp_q.push_back(ev(g, 5, int'(early)));
    exp_q.push_back(ev(g, 4, 0));
    @(negedge clk);
    llrs_loaded[g] = 1'b1;
    t = 0;
    while (!out_valid[g] && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid[g]) chk("valid_timeout", 32'(out_valid[g]), 1);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {out_valid[g], llr_release[g]}, 2'b10);
    end
    out_accept[g] = 1'b1;
    @(negedge clk);
    out_accept[g] = 1'b0;
    chk("rel_pulse", {llr_release[g], out_valid[g], busy[g]}, 3'b101);
    @(posedge clk);
    #1 llrs_loaded[g] = 1'b0;
    @(negedge clk);
    chk("idle_after", {busy[g], llr_release[g]}, 2'b00);
    repeat (4) @(negedge clk);
    chk("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int t;
    rst = 1'b0;
    llrs_loaded = '0; out_accept = '0;
    vn_done = '0; cn_done = '0; out_done = '0; syndrome_ok = '0;
    repeat (3) @(negedge clk);
    chk("rst_out0", outs(0), 0);
    chk("rst_out1", outs(1), 0);
    rst = 1'b1;

    synd_on = 0;
    run_frame(0, 5, 1'b0, 0);
    synd_on = 2;
    run_frame(0, 2, 1'b1, 0);
    run_frame(1, 5, 1'b0, 0);
    synd_on = 0;
    run_frame(0, 5, 1'b0, 20);

    // Watchdog: CN datapath never answers.
    cn_dead = 1'b1;
    exp_q.push_back(ev(0, 1, 0));
    exp_q.push_back(ev(0, 2, 0));
    exp_q.push_back(ev(0, 4, 1));
    @(negedge clk);
    llrs_loaded[0] = 1'b1;
    t = 0;
    while (!cn_start[0] && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (!llr_release[0] && t < 100) begin @(negedge clk); t++; end
    chk("wdog_lat", t, 9);
    chk("wdog_err", 32'(wdog_err[0]), 1);
    @(posedge clk);
    #1 llrs_loaded[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("wdog_sticky", {wdog_err[0], busy[0], out_valid[0]}, 3'b100);
    chk("q_empty_wdog", exp_q.size(), 0);
    cn_dead = 1'b0;

    // Reset during the first CN_WAIT cycle of iteration 3; the late cn_done and a stray vn_done
    // must both be ignored.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev(0, 1, i));
      exp_q.push_back(ev(0, 2, i));
    end
    @(negedge clk);
    llrs_loaded[0] = 1'b1;
    t = 0;
    while (!(cn_start[0] && iter_idx[0] == 4'd3) && t < 200) begin @(negedge clk); t++; end
    chk("it3_reached", {cn_start[0], iter_idx[0]}, 5'h13);
    @(negedge clk);
    rst = 1'b0;
    llrs_loaded[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_out", outs(0), 0);
    rst = 1'b1;
    stray_vn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stray_vn = 1'b0;
    repeat (6) @(negedge clk);
    chk("stray_ignored", {busy[0], vn_start[0], cn_start[0], llr_release[0]}, 4'b0000);
    chk("q_empty_rst", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
